// File: rtl/xnor_act_packer_pkg.sv
// Shared BNN constants: default activation geometry, popcount widths and
// the packer state encoding.
package xnor_act_packer_pkg;

  localparam int BNN_N         = 128;
  localparam int BNN_DEPTH     = 8;
  localparam bit BNN_PAD_BIT   = 1'b0;

  localparam int POPCNT_W      = $clog2(BNN_N) + 1;
  localparam int POPCNT_THRESH = BNN_N / 2;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_FULL = 2'd1,
    ST_DONE = 2'd2
  } pack_state_e;

endpackage

// File: rtl/xnor_act_packer_buf.sv
// Activation word store: DEPTH x N array, one write port, one registered
// read port that returns the pre-write contents on an address collision.
module act_buf_1r1w #(
  parameter int N     = 128,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [N-1:0]             wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [N-1:0]             rd_data
);

  logic [N-1:0] mem [DEPTH];
  logic [N-1:0] rd_data_d;
  logic [N-1:0] rd_data_q;

  always_comb begin
    rd_data_d = mem[rd_addr];
  end

  // Storage has no reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/xnor_act_packer.sv
// Packs a serial stream of thresholded neuron bits LSB-first into N-bit
// activation words and stores them for the next XNOR/popcount layer.
module xnor_act_packer
  import xnor_act_packer_pkg::*;
#(
  parameter int N       = BNN_N,
  parameter int DEPTH   = BNN_DEPTH,
  parameter bit PAD_BIT = BNN_PAD_BIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_bit,
  input  logic                     in_last,
  output logic                     in_ready,
  input  logic                     layer_clear,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [N-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   word_count,
  output logic                     layer_done,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(N);
  localparam int CW = AW + 1;

  pack_state_e   state_q, state_d;
  logic [IW-1:0] bit_idx_q, bit_idx_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] word_count_q, word_count_d;
  logic          overflow_q, overflow_d;
  logic [N-1:0]  word_q, word_d;

  logic [N-1:0]  packed_word;
  logic          wr_en;

  // Word as it would be written now: accepted bits below the index, the
  // incoming bit at the index, padding above it.
  always_comb begin
    packed_word = '0;
    for (int i = 0; i < N; i++) begin
      if (i < int'(bit_idx_q)) begin
        packed_word[i] = word_q[i];
      end else if (i == int'(bit_idx_q)) begin
        packed_word[i] = in_bit;
      end else begin
        packed_word[i] = PAD_BIT;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    wr_ptr_d     = wr_ptr_q;
    word_count_d = word_count_q;
    overflow_d   = overflow_q;
    word_d       = word_q;
    wr_en        = 1'b0;

    if (layer_clear) begin
      state_d      = ST_FILL;
      bit_idx_d    = '0;
      wr_ptr_d     = '0;
      word_count_d = '0;
      overflow_d   = 1'b0;
      word_d       = '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (in_valid) begin
            word_d = packed_word;
            if (in_last || (bit_idx_q == IW'(N - 1))) begin
              wr_en        = 1'b1;
              wr_ptr_d     = wr_ptr_q + AW'(1);
              word_count_d = word_count_q + CW'(1);
              bit_idx_d    = '0;
              word_d       = '0;
              // A last beat always wins over the buffer filling up.
              if (in_last) begin
                state_d = ST_DONE;
              end else if (word_count_q == CW'(DEPTH - 1)) begin
                state_d = ST_FULL;
              end
            end else begin
              bit_idx_d = bit_idx_q + IW'(1);
            end
          end
        end
        ST_FULL: begin
          if (in_valid) begin
            overflow_d = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FILL;
      bit_idx_q    <= '0;
      wr_ptr_q     <= '0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
      word_q       <= '0;
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      wr_ptr_q     <= wr_ptr_d;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_d;
      word_q       <= word_d;
    end
  end

  act_buf_1r1w #(
    .N    (N),
    .DEPTH(DEPTH)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr_q),
    .wr_data(packed_word),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  assign in_ready   = (state_q == ST_FILL);
  assign layer_done = (state_q == ST_DONE);
  assign word_count = word_count_q;
  assign overflow   = overflow_q;

endmodule
